// File: rtl/div_12x6_seq_if.sv
// Handshake and operand/result bundle for the 12/6 sequential divider.
// The master issues operations; the slave (the divider) returns registered results.
interface div_12x6_seq_if;
    localparam int unsigned N = 12;
    localparam int unsigned M = 6;

    logic         start;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/div_12x6_seq.sv
// Sequential restoring divider: 12-bit unsigned dividend / 6-bit unsigned divisor,
// one quotient bit per clock, start/busy/done handshake, divide-by-zero flag.
module div_12x6_seq (
    input  logic           clk,
    input  logic           rst,
    div_12x6_seq_if.slave  bus
);
    localparam int unsigned N  = 12;
    localparam int unsigned M  = 6;
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  sreg;
    logic [M:0]    prem;
    logic [M-1:0]  dreg;
    logic [CW-1:0] cnt;

    logic          busy_q;
    logic          done_q;
    logic          dbz_q;
    logic [N-1:0]  quot_q;
    logic [M-1:0]  rem_q;

    logic [M:0]    trial;
    logic [M:0]    diff;
    logic [M:0]    prem_nxt;
    logic          qbit;
    logic [N-1:0]  sreg_nxt;
    logic          accept;

    // One restoring step: bring down the next dividend bit and try to subtract.
    always_comb begin
        trial    = {prem[M-1:0], sreg[N-1]};
        diff     = trial - {1'b0, dreg};
        qbit     = (trial >= {1'b0, dreg});
        prem_nxt = qbit ? diff : trial;
        sreg_nxt = {sreg[N-2:0], qbit};
        accept   = bus.start && ((state == IDLE) || (state == DONE));
    end

    // A zero divisor takes one pass through RUN with busy low so that done
    // lands one cycle after acceptance; start is ignored in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            prem   <= '0;
            dreg   <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            quot_q <= '0;
            rem_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        sreg   <= bus.dividend;
                        dreg   <= bus.divisor;
                        prem   <= '0;
                        cnt    <= '0;
                        busy_q <= (bus.divisor != '0);
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    if (dreg == '0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        quot_q <= '1;
                        rem_q  <= sreg[M-1:0];
                        dbz_q  <= 1'b1;
                    end else begin
                        sreg <= sreg_nxt;
                        prem <= prem_nxt;
                        cnt  <= cnt + CW'(1);
                        if (cnt == CW'(N - 1)) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            quot_q <= sreg_nxt;
                            rem_q  <= prem_nxt[M-1:0];
                            dbz_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_12x6_seq.sv
// Self-checking bench for div_12x6_seq: directed cases, handshake corners,
// reset abort and random operands against an arithmetic reference.
module tb_div_12x6_seq;
    localparam int unsigned N = 12;
    localparam int unsigned M = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] prev_q = '0;
    logic [M-1:0] prev_r = '0;

    div_12x6_seq_if bus ();

    div_12x6_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a request; called just after a rising edge.
    task automatic launch(input logic [N-1:0] a, input logic [M-1:0] b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
    endtask

    // Accept the launched request on the next edge, then check timing and results.
    // inject: pulse start with junk operands mid-run. chain: hold start into DONE with the next op.
    task automatic finish_op(input string tag, input logic [N-1:0] a, input logic [M-1:0] b,
                             input bit inject, input bit chain,
                             input logic [N-1:0] na, input logic [M-1:0] nb);
        logic [N-1:0] eq;
        logic [M-1:0] er;
        int lat;
        int busy_cycles;
        bit got;
        if (b == '0) begin
            eq = '1;
            er = a[M-1:0];
        end else begin
            eq = N'(a / b);
            er = M'(a % b);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, ".done_at_accept"}, 32'(bus.done), 32'd0);
        busy_cycles = int'(bus.busy);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            busy_cycles += int'(bus.busy);
            if (inject && lat == 4) begin
                bus.dividend = N'($urandom);
                bus.divisor  = M'($urandom_range(1, 63));
                bus.start    = 1'b1;
            end
            if (inject && lat == 5) bus.start = 1'b0;
            if (lat == 6) begin
                chk({tag, ".held_q"}, 32'(bus.quotient), 32'(prev_q));
                chk({tag, ".held_r"}, 32'(bus.remainder), 32'(prev_r));
            end
        end
        chk({tag, ".done_seen"}, 32'(got), 32'd1);
        chk({tag, ".latency"}, 32'(lat), (b == '0) ? 32'd1 : 32'(N));
        chk({tag, ".busy_cycles"}, 32'(busy_cycles), (b == '0) ? 32'd0 : 32'(N));
        chk({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
        chk({tag, ".quotient"}, 32'(bus.quotient), 32'(eq));
        chk({tag, ".remainder"}, 32'(bus.remainder), 32'(er));
        chk({tag, ".dbz"}, 32'(bus.div_by_zero), (b == '0) ? 32'd1 : 32'd0);
        prev_q = eq;
        prev_r = er;
        if (chain) launch(na, nb);
    endtask

    task automatic do_div(input string tag, input logic [N-1:0] a, input logic [M-1:0] b);
        launch(a, b);
        finish_op(tag, a, b, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int dones;
        logic [N-1:0] ra;
        logic [M-1:0] rb;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        chk("reset.q", 32'(bus.quotient), 32'd0);
        chk("reset.r", 32'(bus.remainder), 32'd0);
        chk("reset.dbz", 32'(bus.div_by_zero), 32'd0);

        @(posedge clk); #1;
        do_div("308/11", 12'd308, 6'd11);
        do_div("756/18", 12'd756, 6'd18);
        do_div("100/7", 12'd100, 6'd7);
        do_div("4095/1", 12'd4095, 6'd1);
        do_div("4095/63", 12'd4095, 6'd63);
        do_div("62/63", 12'd62, 6'd63);
        do_div("1234/0", 12'd1234, 6'd0);
        do_div("500/9", 12'd500, 6'd9);

        // start pulse mid-run must not disturb the operation in flight
        launch(12'd3000, 6'd37);
        finish_op("inject", 12'd3000, 6'd37, 1'b1, 1'b0, '0, '0);

        // back-to-back: start held through DONE, including a zero-divisor chain
        launch(12'd2047, 6'd5);
        finish_op("chain1", 12'd2047, 6'd5, 1'b0, 1'b1, 12'd777, 6'd0);
        finish_op("chain2", 12'd777, 6'd0, 1'b0, 1'b1, 12'd1000, 6'd33);
        finish_op("chain3", 12'd1000, 6'd33, 1'b0, 1'b0, '0, '0);

        // reset during RUN aborts silently
        @(posedge clk); #1;
        launch(12'd1000, 6'd7);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort.busy", 32'(bus.busy), 32'd0);
        chk("abort.done", 32'(bus.done), 32'd0);
        chk("abort.q", 32'(bus.quotient), 32'd0);
        chk("abort.r", 32'(bus.remainder), 32'd0);
        chk("abort.dbz", 32'(bus.div_by_zero), 32'd0);
        dones = 0;
        repeat (15) begin
            @(posedge clk); #1;
            dones += int'(bus.done);
        end
        chk("abort.no_done", 32'(dones), 32'd0);
        prev_q = '0;
        prev_r = '0;
        do_div("post_abort", 12'd756, 6'd18);

        for (int i = 0; i < 20; i++) begin
            ra = N'($urandom);
            rb = ((i % 7) == 3) ? 6'd0 : M'($urandom);
            do_div($sformatf("rand%0d", i), ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
